// File: rtl/npc_predict_pkg.sv
// Shared types and constants for the fetch-side next-PC predictor.
// Holds the BTB entry layout, the resolve bundle and the tag helper.
package npc_predict_pkg;

  localparam logic [1:0] CTR_RESET = 2'b01;
  localparam logic [1:0] CTR_ALLOC = 2'b10;

  typedef struct packed {
    logic        valid;
    logic [31:0] tag;
    logic [31:0] target;
    logic [1:0]  ctr;
  } btb_entry_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
    logic        mispredict;
    logic [31:0] redirect_pc;
  } bp_resolve_t;

  // Tag is the PC above the index field, right-aligned so the whole word is compared.
  function automatic logic [31:0] btb_tag(input logic [31:0] pc, input int unsigned idxw);
    return pc >> (idxw + 2);
  endfunction

endpackage

// File: rtl/npc_predict_sat_cnt2.sv
// 2-bit saturating up/down counter step, combinational, zero latency.
// Used by the BTB write path to train the direction counter.
module npc_predict_sat_cnt2 (
  input  logic [1:0] i_ctr,
  input  logic       i_up,
  output logic [1:0] o_ctr
);

  always_comb begin
    o_ctr = i_ctr;
    if (i_up) begin
      if (i_ctr != 2'b11) o_ctr = i_ctr + 2'd1;
    end else begin
      if (i_ctr != 2'b00) o_ctr = i_ctr - 2'd1;
    end
  end

endmodule

// File: rtl/npc_predict.sv
// Fetch PC register with direct-mapped BTB prediction and delay-slot target queueing.
// Lookup is combinational on f_pc; next PC is registered each cycle; stall holds PC and pending target.
module npc_predict
  import npc_predict_pkg::*;
#(
  parameter int          BTB_DEPTH  = 64,
  parameter logic [31:0] RESET_PC   = 32'hBFC00000,
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        stall,
  output logic [31:0] f_pc,
  output logic        f_pred_taken,
  output logic [31:0] f_pred_target,
  output logic        f_in_delay_slot,
  input  logic        exc_valid,
  input  logic        eret,
  input  logic [31:0] cp0_epc,
  input  logic        res_valid,
  input  logic [31:0] res_pc,
  input  logic        res_taken,
  input  logic [31:0] res_target,
  input  logic        res_mispredict,
  input  logic [31:0] res_redirect_pc
);

  localparam int IDXW = $clog2(BTB_DEPTH);

  logic [31:0] r_pc;
  logic        r_pend_valid;
  logic [31:0] r_pend_target;
  btb_entry_t  r_btb [BTB_DEPTH];

  bp_resolve_t     w_res;
  logic [IDXW-1:0] w_idx;
  btb_entry_t      w_ent;
  logic            w_hit;
  logic            w_pred_taken;
  logic [IDXW-1:0] w_res_idx;
  btb_entry_t      w_res_ent;
  logic            w_res_hit;
  logic [1:0]      w_ctr_next;
  logic [31:0]     w_next_pc;
  logic            w_next_pend_valid;
  logic [31:0]     w_next_pend_target;

  always_comb begin
    w_res.valid       = res_valid;
    w_res.pc          = res_pc;
    w_res.taken       = res_taken;
    w_res.target      = res_target;
    w_res.mispredict  = res_mispredict;
    w_res.redirect_pc = res_redirect_pc;
  end

  // Read side sees the entry as it was before any same-cycle update.
  assign w_idx        = r_pc[IDXW+1:2];
  assign w_ent        = r_btb[w_idx];
  assign w_hit        = w_ent.valid && (w_ent.tag == btb_tag(r_pc, IDXW));
  assign w_pred_taken = w_hit && w_ent.ctr[1];

  assign w_res_idx = w_res.pc[IDXW+1:2];
  assign w_res_ent = r_btb[w_res_idx];
  assign w_res_hit = w_res_ent.valid && (w_res_ent.tag == btb_tag(w_res.pc, IDXW));

  npc_predict_sat_cnt2 u_sat_cnt2 (
    .i_ctr (w_res_ent.ctr),
    .i_up  (w_res.taken),
    .o_ctr (w_ctr_next)
  );

  always_comb begin
    w_next_pc          = r_pc + 32'd4;
    w_next_pend_valid  = 1'b0;
    w_next_pend_target = r_pend_target;
    if (exc_valid) begin
      w_next_pc = EXC_VECTOR;
    end else if (eret) begin
      w_next_pc = cp0_epc;
    end else if (w_res.valid && w_res.mispredict) begin
      w_next_pc = w_res.redirect_pc;
    end else if (stall) begin
      w_next_pc         = r_pc;
      w_next_pend_valid = r_pend_valid;
    end else if (r_pend_valid) begin
      // A pending target wins over any prediction from the delay slot itself.
      w_next_pc = r_pend_target;
    end else if (w_pred_taken) begin
      w_next_pend_valid  = 1'b1;
      w_next_pend_target = w_ent.target;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pc          <= RESET_PC;
      r_pend_valid  <= 1'b0;
      r_pend_target <= '0;
    end else begin
      r_pc          <= w_next_pc;
      r_pend_valid  <= w_next_pend_valid;
      r_pend_target <= w_next_pend_target;
    end
  end

  // Flop-based array so the async reset can clear every valid bit.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < BTB_DEPTH; i++) begin
        r_btb[i].valid  <= 1'b0;
        r_btb[i].tag    <= '0;
        r_btb[i].target <= '0;
        r_btb[i].ctr    <= CTR_RESET;
      end
    end else if (w_res.valid) begin
      if (w_res_hit) begin
        r_btb[w_res_idx].ctr <= w_ctr_next;
        if (w_res.taken) r_btb[w_res_idx].target <= w_res.target;
      end else if (w_res.taken) begin
        r_btb[w_res_idx].valid  <= 1'b1;
        r_btb[w_res_idx].tag    <= btb_tag(w_res.pc, IDXW);
        r_btb[w_res_idx].target <= w_res.target;
        r_btb[w_res_idx].ctr    <= CTR_ALLOC;
      end
    end
  end

  assign f_pc            = r_pc;
  assign f_pred_taken    = w_pred_taken;
  assign f_pred_target   = w_ent.target;
  assign f_in_delay_slot = r_pend_valid;

endmodule
